hazard_stall_unit: RTL and testbench

- Scoreboard-based hazard detector and stall/flush controller for the 5-stage MIPS pipeline.
- Tracks the destination registers in flight in EX, MEM and WB, and compares them against the source registers of the instruction in ID.
- Stalls PC and IF/ID and bubbles ID/EX whenever forwarding cannot cover a dependence.
- Pairs with the store-data forwarding unit: a load feeding a store's data register (rt) is left to MEM/WB->EX/MEM forwarding and is not stalled.

---
 rtl/hazard_stall_unit_pkg.sv | 14 +
 rtl/hazard_scoreboard_slot.sv | 15 +
 rtl/hazard_stall_unit.sv | 51 +++++
 tb/tb_hazard_stall_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared register width, zero register and scoreboard slot type
package hazard_stall_unit_pkg;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic [REG_AW-1:0] dest;
  } slot_t;
  function automatic logic slot_match(slot_t s, logic [REG_AW-1:0] r);
    return s.valid && s.reg_write && s.dest != ZERO_REG && s.dest == r;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_slot.sv
// hazard_scoreboard_slot: one registered scoreboard entry with load and clear
module hazard_scoreboard_slot
  import hazard_stall_unit_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  clear,
  input  slot_t d,
  output slot_t q
);
  always_ff @(posedge clk)
    if (reset || clear) q <= '0;
    else if (load) q <= d;
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: scoreboard hazard detector driving pipeline stall, bubble and flush
module hazard_stall_unit #(
  parameter int REG_AW = hazard_stall_unit_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              forwarding,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_store,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              branch_taken_ex,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              bubble_idex,
  output logic              flush_ifid,
  output logic [CNT_W-1:0]  stall_count
);
  import hazard_stall_unit_pkg::*;
  slot_t id_slot, ex_q, mem_q, wb_q;
  logic ex_rs, ex_rt, mem_rs, mem_rt, load_use, interlock, hazard, stall, issue, wb_unused;
  assign id_slot = '{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read, dest: id_dest};
  assign issue = id_valid & ~stall & ~branch_taken_ex;
  hazard_scoreboard_slot u_ex  (.clk(clk), .reset(reset), .load(1'b1), .clear(~issue), .d(id_slot), .q(ex_q));
  hazard_scoreboard_slot u_mem (.clk(clk), .reset(reset), .load(1'b1), .clear(1'b0),   .d(ex_q),    .q(mem_q));
  hazard_scoreboard_slot u_wb  (.clk(clk), .reset(reset), .load(1'b1), .clear(1'b0),   .d(mem_q),   .q(wb_q));
  // WB is written before ID reads the register file, so it never stalls
  assign wb_unused = ^wb_q;
  assign ex_rs  = slot_match(ex_q, id_rs) & id_uses_rs;
  assign ex_rt  = slot_match(ex_q, id_rt) & id_uses_rt;
  assign mem_rs = slot_match(mem_q, id_rs) & id_uses_rs;
  assign mem_rt = slot_match(mem_q, id_rt) & id_uses_rt;
  // store data (rt) from a load is picked up by MEM/WB->EX/MEM forwarding
  assign load_use  = ex_q.mem_read & (ex_rs | (ex_rt & ~id_is_store));
  assign interlock = ex_rs | ex_rt | mem_rs | mem_rt;
  assign hazard    = id_valid & (forwarding ? load_use : interlock);
  assign stall       = hazard & ~branch_taken_ex & ~reset;
  assign stall_pc    = stall;
  assign stall_ifid  = stall;
  assign bubble_idex = stall | (branch_taken_ex & ~reset);
  assign flush_ifid  = branch_taken_ex & ~reset;
  always_ff @(posedge clk)
    if (reset) stall_count <= '0;
    else if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed vector table plus reset and saturation sequences
module tb_hazard_stall_unit;
  localparam int CNT_W = 8;
  localparam int CMAX = (1 << CNT_W) - 1;
  typedef struct {
    bit fwd, vld;
    logic [4:0] rs, rt;
    bit urs, urt, st, rw, mr;
    logic [4:0] dest;
    bit br;
    bit e_stall, e_bubble, e_flush;
    int e_count;
  } vec_t;
  logic clk = 0, reset = 1, forwarding = 0, id_valid = 0;
  logic [4:0] id_rs = 0, id_rt = 0, id_dest = 0;
  logic id_uses_rs = 0, id_uses_rt = 0, id_is_store = 0, id_reg_write = 0, id_mem_read = 0;
  logic branch_taken_ex = 0;
  logic stall_pc, stall_ifid, bubble_idex, flush_ifid;
  logic [CNT_W-1:0] stall_count;
  int n_cmp = 0, n_bad = 0;
  vec_t vecs[27];
  hazard_stall_unit #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .forwarding(forwarding), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_store(id_is_store), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .branch_taken_ex(branch_taken_ex),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    forwarding = v.fwd; id_valid = v.vld; id_rs = v.rs; id_rt = v.rt;
    id_uses_rs = v.urs; id_uses_rt = v.urt; id_is_store = v.st;
    id_reg_write = v.rw; id_mem_read = v.mr; id_dest = v.dest; branch_taken_ex = v.br;
  endtask
  initial begin
    // fwd vld rs rt urs urt st rw mr dest br | stall bubble flush count
    vecs[0]  = '{1,1,29, 0,1,0,0,1,1, 8,0, 0,0,0,0};
    vecs[1]  = '{1,1, 8,17,1,1,0,1,0,10,0, 1,1,0,0};
    vecs[2]  = '{1,1, 8,17,1,1,0,1,0,10,0, 0,0,0,1};
    vecs[3]  = '{1,0, 0, 0,0,0,0,0,0, 0,0, 0,0,0,1};
    vecs[4]  = '{1,1,29, 0,1,0,0,1,1, 8,0, 0,0,0,1};
    vecs[5]  = '{1,1,17, 8,1,1,1,0,0, 0,0, 0,0,0,1};
    vecs[6]  = '{1,0, 0, 0,0,0,0,0,0, 0,0, 0,0,0,1};
    vecs[7]  = '{0,1,17,18,1,1,0,1,0, 9,0, 0,0,0,1};
    vecs[8]  = '{0,1, 9,17,1,1,0,1,0,10,0, 1,1,0,1};
    vecs[9]  = '{0,1, 9,17,1,1,0,1,0,10,0, 1,1,0,2};
    vecs[10] = '{0,1, 9,17,1,1,0,1,0,10,0, 0,0,0,3};
    vecs[11] = '{1,0, 0, 0,0,0,0,0,0, 0,0, 0,0,0,3};
    vecs[12] = '{1,1,29, 0,1,0,0,1,1, 8,0, 0,0,0,3};
    vecs[13] = '{1,1, 8,17,1,1,0,1,0,10,1, 0,1,1,3};
    vecs[14] = '{1,1, 8,17,1,1,0,1,0,10,0, 0,0,0,3};
    vecs[15] = '{1,1,29, 0,1,0,0,1,1, 0,0, 0,0,0,3};
    vecs[16] = '{1,1, 0, 0,1,1,0,1,0, 0,0, 0,0,0,3};
    vecs[17] = '{0,1, 0, 0,1,1,0,1,0, 0,0, 0,0,0,3};
    vecs[18] = '{0,1, 0, 0,1,1,0,1,0, 0,0, 0,0,0,3};
    vecs[19] = '{0,1, 0, 0,1,1,0,1,0,11,0, 0,0,0,3};
    vecs[20] = '{0,1, 0,11,1,1,1,0,0, 0,0, 1,1,0,3};
    vecs[21] = '{0,1, 0,11,1,1,1,0,0, 0,0, 1,1,0,4};
    vecs[22] = '{0,1, 0,11,1,1,1,0,0, 0,0, 0,0,0,5};
    vecs[23] = '{0,1, 0, 0,0,0,0,1,0,12,0, 0,0,0,5};
    vecs[24] = '{0,0,12,12,1,1,0,1,0, 0,0, 0,0,0,5};
    vecs[25] = '{1,1, 0, 0,1,0,0,1,1,13,0, 0,0,0,5};
    vecs[26] = '{1,1, 0,13,1,0,0,1,0,14,0, 0,0,0,5};
    branch_taken_ex = 1;
    tick;
    check("reset_out", 0, {stall_pc, stall_ifid, bubble_idex, flush_ifid}, 4'b0000);
    tick;
    reset = 0;
    branch_taken_ex = 0;
    for (int i = 0; i < 27; i++) begin
      drive(vecs[i]);
      #1;
      check("outs", i, {stall_pc, stall_ifid, bubble_idex, flush_ifid},
            {vecs[i].e_stall, vecs[i].e_stall, vecs[i].e_bubble, vecs[i].e_flush});
      check("count", i, 32'(stall_count), vecs[i].e_count);
      tick;
    end
    // reset in the second cycle of an interlock stall
    drive('{0,1, 0, 0,0,0,0,1,0,15,0, 0,0,0,0});
    tick;
    drive('{0,1,15, 0,1,0,0,0,0, 0,0, 0,0,0,0});
    #1;
    check("rst_stall1", 0, {stall_pc, stall_ifid, bubble_idex, flush_ifid}, 4'b1110);
    tick;
    check("rst_stall2", 0, {stall_pc, stall_ifid, bubble_idex, flush_ifid}, 4'b1110);
    check("rst_cnt_pre", 0, 32'(stall_count), 6);
    reset = 1;
    #1;
    check("rst_during", 0, {stall_pc, stall_ifid, bubble_idex, flush_ifid}, 4'b0000);
    tick;
    reset = 0;
    #1;
    check("rst_after", 0, {stall_pc, stall_ifid, bubble_idex, flush_ifid}, 4'b0000);
    check("rst_cnt", 0, 32'(stall_count), 0);
    tick;
    // two interlock stalls per iteration drive the counter past all-ones
    for (int i = 0; i < 130; i++) begin
      check("sat_cnt", i, 32'(stall_count), (2 * i > CMAX) ? CMAX : 2 * i);
      drive('{0,1, 0, 0,0,0,0,1,0, 5,0, 0,0,0,0});
      tick;
      drive('{0,1, 5, 0,1,0,0,0,0, 0,0, 0,0,0,0});
      #1;
      check("sat_stall", i, 32'(stall_pc), 1);
      tick;
      tick;
      tick;
    end
    check("sat_final", 0, 32'(stall_count), CMAX);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
